prog_loader: RTL and testbench

Serial program loader sitting upstream of the CPU core and its main memory. It receives a framed program image on `rxd`, assembles 12-bit words from byte pairs, and writes them into main memory through the memory write port. It holds the core in reset until a complete frame has been accepted. It reuses the design's clock-enable tick for bit timing.

---
 rtl/loader_pkg.sv | 15 +
 rtl/loader_uart_rx.sv | 97 +++++++++
 rtl/prog_loader.sv | 175 +++++++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: frame FSM state
// encoding and the default frame start marker.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA_LO,
    DATA_HI,
    CSUM
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_uart_rx.sv
// ce-driven 8N1 receiver, LSB first, idle-high line. Emits a one-clock
// o_valid pulse for a good byte and a one-clock o_frame_err pulse when the
// stop bit samples low.
module loader_uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       rxd,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     st;
  rx_state_t     st_next;
  logic          rxd_p0;
  logic          rxd_p1;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          half_hit;
  logic          full_hit;
  logic          shift_en;
  logic          stop_ok;
  logic          stop_bad;
  logic          cnt_clr;

  assign half_hit = ce && (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign full_hit = ce && (cnt == CW'(CLKS_PER_BIT - 1));
  assign o_byte   = shift_q;

  // Two-flop synchroniser on the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!reset_n) st <= RX_IDLE;
    else          st <= st_next;
  end

  // Next state: detect start, confirm it at half a bit, then whole-bit steps.
  always_comb begin
    st_next = st;
    case (st)
      RX_IDLE:  if (ce && !rxd_p1) st_next = RX_START;
      RX_START: if (half_hit) st_next = rxd_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_hit && bit_idx == 3'd7) st_next = RX_STOP;
      RX_STOP:  if (full_hit) st_next = RX_IDLE;
      default:  st_next = RX_IDLE;
    endcase
  end

  // Per-state strobes: sample data bits, judge the stop bit, restart timing.
  always_comb begin
    shift_en = (st == RX_DATA) && full_hit;
    stop_ok  = (st == RX_STOP) && full_hit && rxd_p1;
    stop_bad = (st == RX_STOP) && full_hit && !rxd_p1;
    cnt_clr  = (st == RX_IDLE) || (st_next != st) || full_hit;
  end

  // Bit-timing counter, bit index and the single-clock result pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      bit_idx     <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (cnt_clr)   cnt <= '0;
      else if (ce)   cnt <= cnt + CW'(1);
      if (st != RX_DATA) bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      o_valid     <= stop_ok;
      o_frame_err <= stop_bad;
    end
  end

  // Data shift register, filled LSB first from the top.
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rxd_p1, shift_q[7:1]};
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image (SYNC, LEN, LEN x {lo, hi},
// CSUM), writes 12-bit words into main memory and holds the core in reset
// until a frame is accepted. Checksum comparison is enabled by defining
// PROG_LOADER_CHECKSUM_EN; otherwise the CSUM byte is consumed unchecked.
module prog_loader
  import loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT  = 8,
  parameter logic [11:0] BASE_ADDR     = 12'h000,
  parameter int          TIMEOUT_TICKS = 4096,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        rxd,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_data,
  output logic        mem_we,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  words_loaded
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_ferr;
  loader_state_t state;
  loader_state_t state_next;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          abort;
  logic          last_word;
  logic          start_frame;
  logic          latch_len;
  logic          take_lo;
  logic          do_write;
  logic          set_done;
  logic          set_err;
  logic [7:0]    len_q;
  logic [7:0]    lo_q;
  logic [7:0]    csum_q;

  loader_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .rxd         (rxd),
    .o_byte      (rx_byte),
    .o_valid     (rx_valid),
    .o_frame_err (rx_ferr)
  );

  // A byte arriving on the same tick as the timeout wins over the timeout.
  assign timeout   = (state != IDLE) && ce && (tcnt == TW'(TIMEOUT_TICKS - 1));
  assign abort     = rx_ferr || (timeout && !rx_valid);
  assign last_word = ((words_loaded + 8'd1) == len_q);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: walk the frame byte by byte; any in-frame fault drops to IDLE.
  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (rx_valid && rx_byte == SYNC_BYTE) state_next = LEN;
    end else if (abort) begin
      state_next = IDLE;
    end else if (rx_valid) begin
      case (state)
        LEN:     state_next = (rx_byte == 8'd0) ? IDLE : DATA_LO;
        DATA_LO: state_next = DATA_HI;
        DATA_HI: state_next = last_word ? CSUM : DATA_LO;
        CSUM:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output strobes driving the datapath and status registers.
  always_comb begin
    start_frame = 1'b0;
    latch_len   = 1'b0;
    take_lo     = 1'b0;
    do_write    = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    if (state == IDLE) begin
      start_frame = rx_valid && (rx_byte == SYNC_BYTE);
    end else if (abort) begin
      set_err = 1'b1;
    end else if (rx_valid) begin
      case (state)
        LEN: begin
          if (rx_byte == 8'd0) set_err   = 1'b1;
          else                 latch_len = 1'b1;
        end
        DATA_LO: take_lo  = 1'b1;
        DATA_HI: do_write = 1'b1;
        CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (rx_byte == csum_q) set_done = 1'b1;
          else                   set_err  = 1'b1;
`else
          set_done = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Inter-byte timeout counter, running only inside a frame.
  always_ff @(posedge clk) begin
    if (!reset_n || state == IDLE || rx_valid || rx_ferr) tcnt <= '0;
    else if (ce)                                          tcnt <= tcnt + TW'(1);
  end

  // Memory write port, word counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_data     <= 12'h000;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= 8'd0;
    end else begin
      mem_we <= do_write;
      if (do_write) begin
        mem_addr     <= BASE_ADDR + {4'h0, words_loaded};
        mem_data     <= {rx_byte[3:0], lo_q};
        words_loaded <= words_loaded + 8'd1;
      end
      if (start_frame) begin
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= 8'd0;
        core_hold    <= 1'b1;
      end
      if (set_done) begin
        load_done <= 1'b1;
        core_hold <= 1'b0;
      end
      if (set_err) load_error <= 1'b1;
    end
  end

  // Frame datapath: length, pending low byte and running checksum.
  always_ff @(posedge clk) begin
    if (latch_len) begin
      len_q  <= rx_byte;
      csum_q <= rx_byte;
    end
    if (take_lo) begin
      lo_q   <= rx_byte;
      csum_q <= csum_next(csum_q, rx_byte);
    end
    if (do_write) csum_q <= csum_next(csum_q, rx_byte);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances share the serial line, one at
// BASE_ADDR 0 and one at 12'hFFF to cover address wrap.
module tb_prog_loader;

  localparam int CPB = 8;
  localparam int TO  = 200;

  logic clk = 1'b0;
  logic reset_n;
  logic ce = 1'b0;
  logic rxd;

  logic [11:0] a_addr, a_data, w_addr, w_data;
  logic        a_we, a_hold, a_done, a_err;
  logic        w_we, w_hold, w_done, w_err;
  logic [7:0]  a_words, w_words;

  logic [11:0] la0 [0:63];
  logic [11:0] ld0 [0:63];
  logic [11:0] la1 [0:63];
  logic [11:0] ld1 [0:63];
  int n0 = 0;
  int n1 = 0;

  int vectors = 0;
  int miscompares = 0;

  prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(12'h000), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .rxd(rxd),
    .mem_addr(a_addr), .mem_data(a_data), .mem_we(a_we), .core_hold(a_hold),
    .load_done(a_done), .load_error(a_err), .words_loaded(a_words));

  prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(12'hFFF), .TIMEOUT_TICKS(TO)) dut_w (
    .clk(clk), .reset_n(reset_n), .ce(ce), .rxd(rxd),
    .mem_addr(w_addr), .mem_data(w_data), .mem_we(w_we), .core_hold(w_hold),
    .load_done(w_done), .load_error(w_err), .words_loaded(w_words));

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      ce = ~ce;
    end
  end

  // Write logs, one entry per cycle with mem_we high.
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      la0[6'(n0)] <= a_addr;
      ld0[6'(n0)] <= a_data;
      n0 <= n0 + 1;
    end
    if (w_we === 1'b1) begin
      la1[6'(n1)] <= w_addr;
      ld1[6'(n1)] <= w_data;
      n1 <= n1 + 1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (ce !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    rxd = v;
    wait_ticks(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop) begin
      send_bit(1'b1);
      send_bit(1'b1);
    end
  endtask

  task automatic settle;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_nominal;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'hCD, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'hF0, 1'b1);
    settle();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (a_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", a_we); end
    vectors++; if (a_addr !== 12'h000) begin miscompares++; $display("FAIL reset_addr: got %h want 000", a_addr); end
    vectors++; if (w_addr !== 12'hFFF) begin miscompares++; $display("FAIL reset_addr_w: got %h want fff", w_addr); end
    vectors++; if (a_data !== 12'h000) begin miscompares++; $display("FAIL reset_data: got %h want 000", a_data); end
    vectors++; if (a_hold !== 1'b1) begin miscompares++; $display("FAIL reset_hold: got %b want 1", a_hold); end
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", a_done); end
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", a_err); end
    vectors++; if (a_words !== 8'd0) begin miscompares++; $display("FAIL reset_words: got %0d want 0", a_words); end
    reset_n = 1'b1;
    wait_ticks(4);
    vectors++; if (a_hold !== 1'b1) begin miscompares++; $display("FAIL reset_hold_after: got %b want 1", a_hold); end
  endtask

  task automatic test_nominal;
    int b0;
    b0 = n0;
    send_nominal();
    vectors++; if (n0 - b0 !== 2) begin miscompares++; $display("FAIL nom_writes: got %0d want 2", n0 - b0); end
    vectors++; if (la0[6'(b0)] !== 12'h000 || ld0[6'(b0)] !== 12'h134) begin miscompares++; $display("FAIL nom_w0: got %h@%h want 134@000", ld0[6'(b0)], la0[6'(b0)]); end
    vectors++; if (la0[6'(b0 + 1)] !== 12'h001 || ld0[6'(b0 + 1)] !== 12'hACD) begin miscompares++; $display("FAIL nom_w1: got %h@%h want acd@001", ld0[6'(b0 + 1)], la0[6'(b0 + 1)]); end
    vectors++; if (a_done !== 1'b1) begin miscompares++; $display("FAIL nom_done: got %b want 1", a_done); end
    vectors++; if (a_hold !== 1'b0) begin miscompares++; $display("FAIL nom_hold: got %b want 0", a_hold); end
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL nom_err: got %b want 0", a_err); end
    vectors++; if (a_words !== 8'd2) begin miscompares++; $display("FAIL nom_words: got %0d want 2", a_words); end
    vectors++; if (a_addr !== 12'h001 || a_data !== 12'hACD) begin miscompares++; $display("FAIL nom_held: got %h@%h want acd@001", a_data, a_addr); end
  endtask

  task automatic test_bad_csum;
    int b0;
    logic exp_err, exp_done, exp_hold;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_err = 1'b1; exp_done = 1'b0; exp_hold = 1'b1;
`else
    exp_err = 1'b0; exp_done = 1'b1; exp_hold = 1'b0;
`endif
    b0 = n0;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'hCD, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'hF1, 1'b1);
    settle();
    vectors++; if (n0 - b0 !== 2) begin miscompares++; $display("FAIL bad_writes: got %0d want 2", n0 - b0); end
    vectors++; if (ld0[6'(b0 + 1)] !== 12'hACD) begin miscompares++; $display("FAIL bad_w1: got %h want acd", ld0[6'(b0 + 1)]); end
    vectors++; if (a_err !== exp_err) begin miscompares++; $display("FAIL bad_err: got %b want %b", a_err, exp_err); end
    vectors++; if (a_done !== exp_done) begin miscompares++; $display("FAIL bad_done: got %b want %b", a_done, exp_done); end
    vectors++; if (a_hold !== exp_hold) begin miscompares++; $display("FAIL bad_hold: got %b want %b", a_hold, exp_hold); end
  endtask

  task automatic test_zero_len;
    int b0;
    b0 = n0;
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b1);
    settle();
    vectors++; if (a_err !== 1'b0 || a_done !== 1'b0) begin miscompares++; $display("FAIL zl_sync_clear: got err=%b done=%b want 0 0", a_err, a_done); end
    vectors++; if (a_hold !== 1'b1) begin miscompares++; $display("FAIL zl_sync_hold: got %b want 1", a_hold); end
    send_byte(8'h00, 1'b1);
    settle();
    vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL zl_err: got %b want 1", a_err); end
    send_byte(8'h01, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h01, 1'b1);
    settle();
    vectors++; if (n0 - b0 !== 0) begin miscompares++; $display("FAIL zl_writes: got %0d want 0", n0 - b0); end
    vectors++; if (a_words !== 8'd0) begin miscompares++; $display("FAIL zl_words: got %0d want 0", a_words); end
  endtask

  task automatic test_framing;
    int b0;
    b0 = n0;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b0);
    settle();
    vectors++; if (a_err !== 1'b1 || a_hold !== 1'b1) begin miscompares++; $display("FAIL fe_err: got err=%b hold=%b want 1 1", a_err, a_hold); end
    send_byte(8'h34, 1'b1); send_byte(8'h01, 1'b1);
    settle();
    vectors++; if (n0 - b0 !== 0) begin miscompares++; $display("FAIL fe_writes: got %0d want 0", n0 - b0); end
  endtask

  task automatic test_timeout;
    int b0;
    b0 = n0;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h55, 1'b1);
    wait_ticks(TO - 20);
    vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b want 0", a_err); end
    wait_ticks(30);
    vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b want 1", a_err); end
    vectors++; if (n0 - b0 !== 0) begin miscompares++; $display("FAIL to_nowrite: got %0d want 0", n0 - b0); end
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h77, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h75, 1'b1);
    settle();
    vectors++; if (n0 - b0 !== 1) begin miscompares++; $display("FAIL to_after_writes: got %0d want 1", n0 - b0); end
    vectors++; if (la0[6'(b0)] !== 12'h000 || ld0[6'(b0)] !== 12'h377) begin miscompares++; $display("FAIL to_after_w0: got %h@%h want 377@000", ld0[6'(b0)], la0[6'(b0)]); end
    vectors++; if (a_done !== 1'b1 || a_err !== 1'b0 || a_hold !== 1'b0) begin miscompares++; $display("FAIL to_after_status: got done=%b err=%b hold=%b want 1 0 0", a_done, a_err, a_hold); end
  endtask

  task automatic test_reset_mid;
    int b0;
    b0 = n0;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h34, 1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (a_we !== 1'b0 || a_addr !== 12'h000 || a_data !== 12'h000) begin miscompares++; $display("FAIL rm_port: got we=%b %h@%h want 0 000@000", a_we, a_data, a_addr); end
    vectors++; if (a_hold !== 1'b1 || a_done !== 1'b0 || a_err !== 1'b0 || a_words !== 8'd0) begin miscompares++; $display("FAIL rm_status: got hold=%b done=%b err=%b words=%0d want 1 0 0 0", a_hold, a_done, a_err, a_words); end
    rxd = 1'b1;
    reset_n = 1'b1;
    wait_ticks(40);
    vectors++; if (n0 - b0 !== 0) begin miscompares++; $display("FAIL rm_nowrite: got %0d want 0", n0 - b0); end
    vectors++; if (a_words !== 8'd0 || a_hold !== 1'b1) begin miscompares++; $display("FAIL rm_after: got words=%0d hold=%b want 0 1", a_words, a_hold); end
  endtask

  task automatic test_reload_wrap;
    int b1;
    send_nominal();
    vectors++; if (w_hold !== 1'b0 || w_done !== 1'b1) begin miscompares++; $display("FAIL rw_pre: got hold=%b done=%b want 0 1", w_hold, w_done); end
    b1 = n1;
    send_byte(8'hA5, 1'b1);
    settle();
    vectors++; if (w_hold !== 1'b1 || w_done !== 1'b0) begin miscompares++; $display("FAIL rw_sync_hold: got hold=%b done=%b want 1 0", w_hold, w_done); end
    send_byte(8'h02, 1'b1); send_byte(8'hBC, 1'b1); send_byte(8'hF5, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h5A, 1'b1);
    settle();
    vectors++; if (n1 - b1 !== 2) begin miscompares++; $display("FAIL rw_writes: got %0d want 2", n1 - b1); end
    vectors++; if (la1[6'(b1)] !== 12'hFFF || ld1[6'(b1)] !== 12'h5BC) begin miscompares++; $display("FAIL rw_w0: got %h@%h want 5bc@fff", ld1[6'(b1)], la1[6'(b1)]); end
    vectors++; if (la1[6'(b1 + 1)] !== 12'h000 || ld1[6'(b1 + 1)] !== 12'h312) begin miscompares++; $display("FAIL rw_w1: got %h@%h want 312@000", ld1[6'(b1 + 1)], la1[6'(b1 + 1)]); end
    vectors++; if (w_hold !== 1'b0 || w_done !== 1'b1 || w_words !== 8'd2) begin miscompares++; $display("FAIL rw_end: got hold=%b done=%b words=%0d want 0 1 2", w_hold, w_done, w_words); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_csum();
    test_zero_len();
    test_framing();
    test_timeout();
    test_reset_mid();
    test_reload_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
